fpnew_noncomp_wb: RTL and testbench

- Writeback collector on the consumer side of the non-computational FP unit's output handshake (result, status, extension bit, class mask, is_class, tag).
- Formats each result into an Flen-wide register value: NaN-boxed float, sign/zero-extended integer, or zero-extended class mask.
- Buffers results in a 2-entry FIFO and accumulates sticky fflags.
- Sits between the non-comp unit and the FP/int register-file write port.

---
 rtl/fpnew_noncomp_wb.sv | 132 +++++++++++++
 tb/tb_fpnew_noncomp_wb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_noncomp_wb.sv
// Writeback collector: formats non-comp FP results into Flen-wide register data, buffers 2 entries, keeps sticky fflags.
// Latency: 1 cycle from accepted input to out_valid_o; there is no same-cycle bypass.
// Backpressure: in_ready_o comes from the registered count only and drops when 2 entries are held.
module fpnew_noncomp_wb #(
    parameter int unsigned Width    = 32,  // source format width (FP32)
    parameter int unsigned Flen     = 64,  // destination register width, >= Width
    parameter int unsigned TagWidth = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [Width-1:0]    result_i,
    input  logic [4:0]          status_i,
    input  logic                extension_bit_i,
    input  logic [9:0]          class_mask_i,
    input  logic                is_class_i,
    input  logic [TagWidth-1:0] tag_i,
    input  logic                flush_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [Flen-1:0]     wdata_o,
    output logic [4:0]          status_o,
    output logic [TagWidth-1:0] tag_o,
    output logic [4:0]          fflags_o,
    input  logic                clear_fflags_i,
    output logic [15:0]         retired_o
);

    logic [1:0]          count_q, count_d;
    logic                wptr_q, wptr_d;
    logic                rptr_q, rptr_d;
    logic [Flen-1:0]     wdata_mem_q  [2];
    logic [Flen-1:0]     wdata_mem_d  [2];
    logic [4:0]          status_mem_q [2];
    logic [4:0]          status_mem_d [2];
    logic [TagWidth-1:0] tag_mem_q    [2];
    logic [TagWidth-1:0] tag_mem_d    [2];
    logic [4:0]          fflags_q, fflags_d;
    logic [15:0]         retired_q, retired_d;

    logic                push;
    logic                pop;
    logic [Flen-1:0]     fmt_data;

    // Register value for the incoming result; the fill is only present when Flen is wider than the source
    generate
        if (Flen > Width) begin : g_fill
            always_comb begin
                fmt_data = is_class_i ? Flen'(class_mask_i)
                                      : {{(Flen-Width){extension_bit_i}}, result_i};
            end
        end else begin : g_nofill
            always_comb begin
                fmt_data = is_class_i ? Flen'(class_mask_i) : result_i;
            end
        end
    endgenerate

    // Handshake outputs, head entry view (zeroed when empty so reset/flush leave clean outputs)
    always_comb begin
        in_ready_o  = (count_q < 2'd2);
        out_valid_o = (count_q != 2'd0);
        wdata_o     = out_valid_o ? wdata_mem_q[rptr_q]  : '0;
        status_o    = out_valid_o ? status_mem_q[rptr_q] : '0;
        tag_o       = out_valid_o ? tag_mem_q[rptr_q]    : '0;
        fflags_o    = fflags_q;
        retired_o   = retired_q;
        push        = in_valid_i && in_ready_o;
        pop         = out_valid_o && out_ready_i;
    end

    // Next-state: FIFO storage, pointers, count, sticky flags and retire counter
    always_comb begin
        wdata_mem_d  = wdata_mem_q;
        status_mem_d = status_mem_q;
        tag_mem_d    = tag_mem_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;

        if (flush_i) begin
            // Flush empties the buffer; a push in the same cycle is dropped
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                wdata_mem_d[wptr_q]  = fmt_data;
                status_mem_d[wptr_q] = status_i;
                tag_mem_d[wptr_q]    = tag_i;
                wptr_d               = ~wptr_q;
            end
            if (pop) begin
                rptr_d = ~rptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        // A pop still retires and contributes flags even during a flush
        fflags_d  = (clear_fflags_i ? 5'd0 : fflags_q) | (pop ? status_o : 5'd0);
        retired_d = retired_q + 16'(pop);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q      <= 2'd0;
            wptr_q       <= 1'b0;
            rptr_q       <= 1'b0;
            wdata_mem_q  <= '{default: '0};
            status_mem_q <= '{default: '0};
            tag_mem_q    <= '{default: '0};
            fflags_q     <= 5'd0;
            retired_q    <= 16'd0;
        end else begin
            count_q      <= count_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            wdata_mem_q  <= wdata_mem_d;
            status_mem_q <= status_mem_d;
            tag_mem_q    <= tag_mem_d;
            fflags_q     <= fflags_d;
            retired_q    <= retired_d;
        end
    end

endmodule

// File: tb/tb_fpnew_noncomp_wb.sv
// Directed bench for fpnew_noncomp_wb (FP32 source, Flen=64, 4-bit tag).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed constants.
module tb_fpnew_noncomp_wb;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] result_i;
    logic [4:0]  status_i;
    logic        extension_bit_i;
    logic [9:0]  class_mask_i;
    logic        is_class_i;
    logic [3:0]  tag_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] wdata_o;
    logic [4:0]  status_o;
    logic [3:0]  tag_o;
    logic [4:0]  fflags_o;
    logic        clear_fflags_i;
    logic [15:0] retired_o;

    int checks   = 0;
    int failures = 0;

    fpnew_noncomp_wb #(.Width(32), .Flen(64), .TagWidth(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .result_i        (result_i),
        .status_i        (status_i),
        .extension_bit_i (extension_bit_i),
        .class_mask_i    (class_mask_i),
        .is_class_i      (is_class_i),
        .tag_i           (tag_i),
        .flush_i         (flush_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .wdata_o         (wdata_o),
        .status_o        (status_o),
        .tag_o           (tag_o),
        .fflags_o        (fflags_o),
        .clear_fflags_i  (clear_fflags_i),
        .retired_o       (retired_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] res, input logic [4:0] st, input logic ext,
                          input logic cls, input logic [9:0] mask, input logic [3:0] tg);
        result_i        = res;
        status_i        = st;
        extension_bit_i = ext;
        is_class_i      = cls;
        class_mask_i    = mask;
        tag_i           = tg;
    endtask

    initial begin
        rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0; clear_fflags_i = 1'b0;
        set_in(32'h0, 5'h0, 1'b0, 1'b0, 10'h0, 4'h0);
        step(); step();
        rst_ni = 1'b1;

        // Reset state
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_in_ready",  64'(in_ready_o),  64'd1);
        check("rst_wdata",     wdata_o,          64'd0);
        check("rst_fflags",    64'(fflags_o),    64'd0);
        check("rst_retired",   64'(retired_o),   64'd0);

        // NaN-boxed float, one-cycle latency, no bypass
        set_in(32'h3F80_0000, 5'h0, 1'b1, 1'b0, 10'h0, 4'd1);
        in_valid_i = 1'b1;
        check("no_bypass", 64'(out_valid_o), 64'd0);
        step();
        in_valid_i = 1'b0;
        check("box_valid",  64'(out_valid_o), 64'd1);
        check("box_wdata",  wdata_o,          64'hFFFF_FFFF_3F80_0000);
        check("box_fflags", 64'(fflags_o),    64'd0);
        out_ready_i = 1'b1; step(); out_ready_i = 1'b0;
        check("box_popped", 64'(out_valid_o), 64'd0);
        check("box_retired", 64'(retired_o),  64'd1);

        // Zero-extended comparison result
        set_in(32'h0000_0001, 5'h0, 1'b0, 1'b0, 10'h0, 4'd2);
        in_valid_i = 1'b1; step(); in_valid_i = 1'b0;
        check("cmp_wdata", wdata_o, 64'h0000_0000_0000_0001);
        out_ready_i = 1'b1; step(); out_ready_i = 1'b0;

        // Classification: mask zero-extended, result and extension bit ignored
        set_in(32'hDEAD_BEEF, 5'h0, 1'b1, 1'b1, 10'h040, 4'd3);
        in_valid_i = 1'b1; step(); in_valid_i = 1'b0;
        check("cls_wdata", wdata_o, 64'h0000_0000_0000_0040);
        check("cls_tag",   64'(tag_o), 64'd3);
        out_ready_i = 1'b1; step(); out_ready_i = 1'b0;
        check("cls_retired", 64'(retired_o), 64'd3);

        // Backpressure: two accepts fill the buffer, third stalls, order preserved
        in_valid_i = 1'b1;
        set_in(32'h1111_0001, 5'h0, 1'b0, 1'b0, 10'h0, 4'd1); step();
        check("bp1_in_ready", 64'(in_ready_o), 64'd1);
        set_in(32'h1111_0002, 5'h0, 1'b0, 1'b0, 10'h0, 4'd2); step();
        check("bp2_in_ready", 64'(in_ready_o), 64'd0);
        check("bp2_tag",      64'(tag_o),      64'd1);
        set_in(32'h1111_0003, 5'h0, 1'b0, 1'b0, 10'h0, 4'd3); step();
        check("bp3_in_ready", 64'(in_ready_o), 64'd0);
        check("bp3_tag",      64'(tag_o),      64'd1);
        check("bp3_wdata",    wdata_o,         64'h0000_0000_1111_0001);
        out_ready_i = 1'b1; step(); out_ready_i = 1'b0;
        check("bp_pop_tag",      64'(tag_o),      64'd2);
        check("bp_pop_in_ready", 64'(in_ready_o), 64'd1);
        step();
        in_valid_i = 1'b0;
        check("bp_acc3_tag",      64'(tag_o),      64'd2);
        check("bp_acc3_in_ready", 64'(in_ready_o), 64'd0);
        out_ready_i = 1'b1; step();
        check("bp_tag3",    64'(tag_o),   64'd3);
        check("bp_wdata3",  wdata_o,      64'h0000_0000_1111_0003);
        step(); out_ready_i = 1'b0;
        check("bp_empty",   64'(out_valid_o), 64'd0);
        check("bp_retired", 64'(retired_o),   64'd6);

        // Sticky flags: NV then NX
        in_valid_i = 1'b1;
        set_in(32'h0, 5'h10, 1'b0, 1'b0, 10'h0, 4'd4); step();
        set_in(32'h0, 5'h01, 1'b0, 1'b0, 10'h0, 4'd5); step();
        in_valid_i = 1'b0;
        check("ff_before_pop", 64'(fflags_o), 64'd0);
        check("ff_head_status", 64'(status_o), 64'h10);
        out_ready_i = 1'b1; step();
        check("ff_nv", 64'(fflags_o), 64'h10);
        step(); out_ready_i = 1'b0;
        check("ff_nv_nx", 64'(fflags_o), 64'h11);
        // Clear together with a pop of NV leaves just NV
        in_valid_i = 1'b1;
        set_in(32'h0, 5'h10, 1'b0, 1'b0, 10'h0, 4'd6); step();
        in_valid_i = 1'b0;
        clear_fflags_i = 1'b1; out_ready_i = 1'b1; step(); out_ready_i = 1'b0;
        check("ff_clear_pop", 64'(fflags_o),  64'h10);
        check("ff_retired",   64'(retired_o), 64'd9);
        step(); clear_fflags_i = 1'b0;
        check("ff_clear_only", 64'(fflags_o), 64'd0);

        // Flush with concurrent pop and a dropped push
        in_valid_i = 1'b1;
        set_in(32'h0, 5'h04, 1'b0, 1'b0, 10'h0, 4'd7); step();
        set_in(32'h0, 5'h02, 1'b0, 1'b0, 10'h0, 4'd8); step();
        check("fl_full", 64'(in_ready_o), 64'd0);
        set_in(32'h0, 5'h08, 1'b0, 1'b0, 10'h0, 4'd9);
        flush_i = 1'b1; out_ready_i = 1'b1; step();
        flush_i = 1'b0; out_ready_i = 1'b0; in_valid_i = 1'b0;
        check("fl_valid",    64'(out_valid_o), 64'd0);
        check("fl_in_ready", 64'(in_ready_o),  64'd1);
        check("fl_retired",  64'(retired_o),   64'd10);
        check("fl_fflags",   64'(fflags_o),    64'h04);
        step();
        check("fl_push_dropped", 64'(out_valid_o), 64'd0);

        // Retire counter to 0xFFFF with streaming push+pop, then wrap
        set_in(32'h0, 5'h0, 1'b0, 1'b0, 10'h0, 4'd0);
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        for (int i = 0; i < 65525; i++) step();
        in_valid_i = 1'b0;
        step();
        check("wrap_ffff",   64'(retired_o),   64'hFFFF);
        check("wrap_empty",  64'(out_valid_o), 64'd0);
        check("wrap_fflags", 64'(fflags_o),    64'h04);
        in_valid_i = 1'b1; step(); in_valid_i = 1'b0; step();
        check("wrap_zero", 64'(retired_o), 64'd0);

        // Reset with an entry buffered and an upstream valid in the reset cycle
        in_valid_i = 1'b1; step(); in_valid_i = 1'b0; step();
        out_ready_i = 1'b0;
        check("pre_rst_retired", 64'(retired_o), 64'd1);
        set_in(32'h0000_ABCD, 5'h08, 1'b1, 1'b0, 10'h0, 4'd9);
        in_valid_i = 1'b1; step();
        check("pre_rst_valid", 64'(out_valid_o), 64'd1);
        set_in(32'h0000_1234, 5'h08, 1'b1, 1'b0, 10'h0, 4'd10);
        rst_ni = 1'b0; step();
        rst_ni = 1'b1; in_valid_i = 1'b0;
        check("mid_rst_valid",    64'(out_valid_o), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready_o),  64'd1);
        check("mid_rst_wdata",    wdata_o,          64'd0);
        check("mid_rst_status",   64'(status_o),    64'd0);
        check("mid_rst_tag",      64'(tag_o),       64'd0);
        check("mid_rst_fflags",   64'(fflags_o),    64'd0);
        check("mid_rst_retired",  64'(retired_o),   64'd0);
        step();
        check("rst_cycle_push_dropped", 64'(out_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
